vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA controller.
- Timings, sync polarities and counter width are parameters.
- Adds a pixel clock-enable input, registered glitch-free sync/blank outputs aligned to the counters, active-area pixel coordinates, line/frame end strobes and a frame counter.
- Sits between the pixel clock domain and the pixel generator / framebuffer reader.

---
 rtl/vga_timing_gen.sv | 116 +++++++++++
 tb/tb_vga_timing_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable.
// Sync/blank/coordinate outputs are registered from next-state counters so they line up with hc/vc.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 29,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  output logic [CNT_W-1:0]   hc,
  output logic [CNT_W-1:0]   vc,
  output logic               hsync,
  output logic               vsync,
  output logic               bright,
  output logic [CNT_W-1:0]   px_x,
  output logic [CNT_W-1:0]   px_y,
  output logic               line_end,
  output logic               frame_end,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HA0     = H_SYNC + H_BP;
  localparam int VA0     = V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA_BEG   = CNT_W'(HA0);
  localparam logic [CNT_W-1:0] HA_END   = CNT_W'(HA0 + H_ACTIVE);
  localparam logic [CNT_W-1:0] VA_BEG   = CNT_W'(VA0);
  localparam logic [CNT_W-1:0] VA_END   = CNT_W'(VA0 + V_ACTIVE);

  logic [CNT_W-1:0]   hc_q, hc_d;
  logic [CNT_W-1:0]   vc_q, vc_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               bright_q, bright_d;
  logic [CNT_W-1:0]   px_x_q, px_x_d;
  logic [CNT_W-1:0]   px_y_q, px_y_d;
  logic [FRAME_W-1:0] frame_q, frame_d;

  assign line_end  = ce & (hc_q == H_LAST);
  assign frame_end = line_end & (vc_q == V_LAST);

  // Decode from the next counter values so the registered outputs match hc/vc in the same cycle.
  always_comb begin
    hc_d     = hc_q;
    vc_d     = vc_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    bright_d = bright_q;
    px_x_d   = px_x_q;
    px_y_d   = px_y_q;
    frame_d  = frame_q;
    if (ce) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
      hsync_d  = (hc_d < H_SYNC_E) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d  = (vc_d < V_SYNC_E) ? VSYNC_POL : ~VSYNC_POL;
      bright_d = (hc_d >= HA_BEG) && (hc_d < HA_END) &&
                 (vc_d >= VA_BEG) && (vc_d < VA_END);
      px_x_d   = bright_d ? hc_d - HA_BEG : '0;
      px_y_d   = bright_d ? vc_d - VA_BEG : '0;
      if (frame_end) frame_d = frame_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hc_q     <= '0;
      vc_q     <= '0;
      hsync_q  <= HSYNC_POL;
      vsync_q  <= VSYNC_POL;
      bright_q <= 1'b0;
      px_x_q   <= '0;
      px_y_q   <= '0;
      frame_q  <= '0;
    end else begin
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      bright_q <= bright_d;
      px_x_q   <= px_x_d;
      px_y_q   <= px_y_d;
      frame_q  <= frame_d;
    end
  end

  assign hc        = hc_q;
  assign vc        = vc_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign bright    = bright_q;
  assign px_x      = px_x_q;
  assign px_y      = px_y_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default VGA, SVGA with active-high syncs, and a tiny raster for frame wrap.
// All three share clock, reset and ce; a position-count model predicts every output.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        br;
    logic [10:0] px;
    logic [10:0] py;
    logic        le;
    logic        fe;
    logic [7:0]  fc;
  } obs_t;

  logic clk;
  logic rst;
  logic ce;

  logic [9:0]  hcA, vcA, pxA, pyA;
  logic        hsA, vsA, brA, leA, feA;
  logic [7:0]  fcA;
  logic [10:0] hcB, vcB, pxB, pyB;
  logic        hsB, vsB, brB, leB, feB;
  logic [7:0]  fcB;
  logic [10:0] hcC, vcC, pxC, pyC;
  logic        hsC, vsC, brC, leC, feC;
  logic [7:0]  fcC;

  int checkCount = 0;
  int passCount  = 0;
  int t          = 0;
  int cur        = 0;
  bit checkEn    = 0;
  bit toggleMon  = 0;
  int leWhileLow = 0;
  int lePulses   = 0;

  vga_timing_gen uA (
    .clk(clk), .rst(rst), .ce(ce), .hc(hcA), .vc(vcA), .hsync(hsA), .vsync(vsA),
    .bright(brA), .px_x(pxA), .px_y(pyA), .line_end(leA), .frame_end(feA), .frame_cnt(fcA)
  );

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(11), .FRAME_W(8)
  ) uB (
    .clk(clk), .rst(rst), .ce(ce), .hc(hcB), .vc(vcB), .hsync(hsB), .vsync(vsB),
    .bright(brB), .px_x(pxB), .px_y(pyB), .line_end(leB), .frame_end(feB), .frame_cnt(fcB)
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(11), .FRAME_W(8)
  ) uC (
    .clk(clk), .rst(rst), .ce(ce), .hc(hcC), .vc(vcC), .hsync(hsC), .vsync(vsC),
    .bright(brC), .px_x(pxC), .px_y(pyC), .line_end(leC), .frame_end(feC), .frame_cnt(fcC)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // t counts accepted pixels since reset; every output is a pure function of t and ce.
  always @(posedge clk or negedge rst) begin
    if (!rst) t <= 0;
    else if (ce) t <= t + 1;
  end

  function automatic obs_t model(int ha, int hfp, int hsw, int hbp, int va, int vfp, int vsw,
                                 int vbp, bit hpol, bit vpol, int pos, logic ceNow);
    obs_t r;
    int ht, vt, p, h, v, x0, y0;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    p  = pos % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    x0 = hsw + hbp;
    y0 = vsw + vbp;
    r.hc = 11'(h);
    r.vc = 11'(v);
    r.hs = (h < hsw) ? hpol : !hpol;
    r.vs = (v < vsw) ? vpol : !vpol;
    r.br = (h >= x0) && (h < x0 + ha) && (v >= y0) && (v < y0 + va);
    r.px = r.br ? 11'(h - x0) : 11'd0;
    r.py = r.br ? 11'(v - y0) : 11'd0;
    r.le = ceNow && (h == ht - 1);
    r.fe = r.le && (v == vt - 1);
    r.fc = 8'((pos / (ht * vt)) % 256);
    return r;
  endfunction

  task automatic checkOutput(string name, obs_t act, obs_t exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s t=%0d: got hc=%0d vc=%0d hs=%b vs=%b br=%b px=%0d py=%0d le=%b fe=%b fc=%0d, required hc=%0d vc=%0d hs=%b vs=%b br=%b px=%0d py=%0d le=%b fe=%b fc=%0d",
               name, t, act.hc, act.vc, act.hs, act.vs, act.br, act.px, act.py, act.le, act.fe, act.fc,
               exp.hc, exp.vc, exp.hs, exp.vs, exp.br, exp.px, exp.py, exp.le, exp.fe, exp.fc);
    end else begin
      passCount++;
    end
  endtask

  task automatic checkLit(string name, int act, int exp);
    checkCount++;
    if (act != exp) $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    else passCount++;
  endtask

  // One compare per DUT per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      obs_t a, b, c;
      a = '{hc: 11'(hcA), vc: 11'(vcA), hs: hsA, vs: vsA, br: brA, px: 11'(pxA), py: 11'(pyA),
            le: leA, fe: feA, fc: fcA};
      b = '{hc: hcB, vc: vcB, hs: hsB, vs: vsB, br: brB, px: pxB, py: pyB, le: leB, fe: feB, fc: fcB};
      c = '{hc: hcC, vc: vcC, hs: hsC, vs: vsC, br: brC, px: pxC, py: pyC, le: leC, fe: feC, fc: fcC};
      checkOutput("vgaA", a, model(640, 16, 96, 48, 480, 10, 2, 29, 1'b0, 1'b0, t, ce));
      checkOutput("svgaB", b, model(800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, t, ce));
      checkOutput("tinyC", c, model(6, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0, t, ce));
    end
    if (toggleMon) begin
      if (!ce && leA) leWhileLow++;
      if (leA) lePulses++;
    end
  end

  task automatic goTo(int target);
    repeat (target - cur) @(posedge clk);
    cur = target;
    @(negedge clk);
  endtask

  task automatic applyStimulus();
    rst = 1'b0;
    ce  = 1'b0;
    #1 checkEn = 1;
    repeat (3) @(negedge clk);
    checkLit("rstA_hc", int'(hcA), 0);
    checkLit("rstA_vc", int'(vcA), 0);
    checkLit("rstA_hsync", int'(hsA), 0);
    checkLit("rstA_vsync", int'(vsA), 0);
    checkLit("rstA_bright", int'(brA), 0);
    checkLit("rstA_frame", int'(fcA), 0);
    checkLit("rstB_hsync", int'(hsB), 1);
    checkLit("rstB_vsync", int'(vsB), 1);

    @(posedge clk);
    #1 rst = 1'b1;
    ce = 1'b1;
    cur = 0;
    goTo(1);
    checkLit("firstCe_hc", int'(hcA), 1);
    checkLit("firstCe_vc", int'(vcA), 0);
    goTo(88);
    checkLit("tinyLastVis_px", int'(pxC), 5);
    checkLit("tinyLastVis_py", int'(pyC), 3);
    checkLit("tinyLastVis_br", int'(brC), 1);
    goTo(89);
    checkLit("tinyPastVis_br", int'(brC), 0);
    checkLit("tinyPastVis_px", int'(pxC), 0);
    goTo(95);
    checkLit("hsyncA_95", int'(hsA), 0);
    goTo(96);
    checkLit("hsyncA_96", int'(hsA), 1);
    checkLit("tinyRow7_br", int'(brC), 0);
    goTo(103);
    checkLit("tinyFrameEnd", int'(feC), 1);
    goTo(104);
    checkLit("tinyWrap_hc", int'(hcC), 0);
    checkLit("tinyWrap_vc", int'(vcC), 0);
    checkLit("tinyWrap_fc", int'(fcC), 1);
    goTo(127);
    checkLit("hsyncB_127", int'(hsB), 1);
    goTo(128);
    checkLit("hsyncB_128", int'(hsB), 0);
    goTo(799);
    checkLit("lineEndA_799", int'(leA), 1);
    goTo(800);
    checkLit("lineWrapA_hc", int'(hcA), 0);
    checkLit("lineWrapA_vc", int'(vcA), 1);
    checkLit("lineEndA_0", int'(leA), 0);
    goTo(24943);
    checkLit("brightA_143", int'(brA), 0);
    goTo(24944);
    checkLit("brightA_144", int'(brA), 1);
    checkLit("brightA_px", int'(pxA), 0);
    checkLit("brightA_py", int'(pyA), 0);
    goTo(26623);
    checkLit("tinyFc255", int'(fcC), 255);
    goTo(26624);
    checkLit("tinyFcWrap", int'(fcC), 0);
    goTo(28727);
    checkLit("brightB_215", int'(brB), 0);
    goTo(28728);
    checkLit("brightB_216", int'(brB), 1);
    checkLit("brightB_vc", int'(vcB), 27);

    // Half-rate ce across A's line boundary at hc=799.
    toggleMon = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1 ce = ~ce;
    end
    @(negedge clk);
    toggleMon = 0;
    checkLit("lineEndWhileCeLow", leWhileLow, 0);
    checkLit("lineEndPulsesA", lePulses, 1);

    // Asynchronous reset in the middle of a line.
    @(posedge clk);
    #3 rst = 1'b0;
    ce = 1'b0;
    @(negedge clk);
    checkLit("midRstA_hc", int'(hcA), 0);
    checkLit("midRstA_vc", int'(vcA), 0);
    checkLit("midRstA_hsync", int'(hsA), 0);
    checkLit("midRstA_bright", int'(brA), 0);
    checkLit("midRstA_frame", int'(fcA), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkLit("postRstA_hc", int'(hcA), 1);
    checkLit("postRstA_vc", int'(vcA), 0);
    repeat (20) @(negedge clk);
    checkEn = 0;
  endtask

  initial begin
    applyStimulus();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
